// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and receive-entry layout for uart_rx_param
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_state_t;

  localparam int UART_MAX_DATA_BITS = 9;

  // Widest entry layout; a receiver instance packs only its DATA_BITS low data bits.
  typedef struct packed {
    logic                          perr;
    logic                          ferr;
    logic [UART_MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  function automatic int entry_width(input int data_bits, input bit with_parity);
    return data_bits + (with_parity ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead synchronous FIFO holding received characters and their flags
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with FIFO and CTS; parity via UART_RX_PARITY_EN
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0,
  parameter int FIFO_DEPTH    = 4,
  parameter int CTS_THRESHOLD = FIFO_DEPTH - 1
) (
  input  logic                          uart_sampling_clk,
  input  logic                          rst,
  input  logic                          USB_RX,
  input  logic                          rx_ready,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          USB_CTS,
  output logic [2:0]                    state_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
  localparam int EW = entry_width(DATA_BITS, 1'b1);
`else
  localparam int EW = entry_width(DATA_BITS, 1'b0);
`endif

  uart_state_t          state;
  logic                 rx_meta;
  logic                 rx;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bcnt;
  logic                 scnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr;
  logic                 ferr_n;
  logic                 push_q;
  logic [EW-1:0]        push_entry;
  logic [EW-1:0]        head;
  logic                 full;
  logic                 empty;
  logic                 pop;
`ifdef UART_RX_PARITY_EN
  logic                 perr;
`endif

  assign ferr_n = ferr | ~rx;

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= USB_RX;
      rx      <= rx_meta;
    end
  end

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      scnt       <= 1'b0;
      shreg      <= '0;
      ferr       <= 1'b0;
      push_q     <= 1'b0;
      push_entry <= '0;
`ifdef UART_RX_PARITY_EN
      perr       <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      case (state)
        S_IDLE: if (!rx) begin
          state <= S_START;
          cnt   <= '0;
        end
        S_START: if (cnt == MID) begin
          cnt <= '0;
          if (rx) begin
            state <= S_IDLE;
          end else begin
            state <= S_DATA;
            bcnt  <= '0;
            scnt  <= 1'b0;
            ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr  <= 1'b0;
`endif
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_DATA: if (cnt == LAST) begin
          cnt   <= '0;
          shreg <= {rx, shreg[DATA_BITS-1:1]};
          bcnt  <= bcnt + 1'b1;
          if (bcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (cnt == LAST) begin
          cnt   <= '0;
          perr  <= ((^shreg) ^ rx) != (PARITY_ODD != 0);
          state <= S_STOP;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        S_STOP: if (cnt == LAST) begin
          cnt  <= '0;
          scnt <= scnt + 1'b1;
          ferr <= ferr_n;
          if (scnt == 1'(STOP_BITS - 1)) begin
            push_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            push_entry <= {perr, ferr_n, shreg};
`else
            push_entry <= {ferr_n, shreg};
`endif
            // A low stop bit means a break may be in progress; wait for the line to rise.
            state <= ferr_n ? S_BREAK : S_IDLE;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_BREAK: if (rx) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pop = rx_valid && rx_ready;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (uart_sampling_clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      USB_CTS <= 1'b1;
    end else begin
      if (push_q && full && !pop) overrun <= 1'b1;
      else if (clr_err)           overrun <= 1'b0;
      USB_CTS <= (fifo_count >= ($clog2(FIFO_DEPTH)+1)'(CTS_THRESHOLD));
    end
  end

  assign rx_valid  = !empty;
  assign rx_data   = head[DATA_BITS-1:0];
  assign frame_err = head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
  assign parity_err = head[DATA_BITS+1];
`else
  assign parity_err = 1'b0;
`endif
  assign state_out = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param (8 data bits, x16, 1 stop)
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int OS = 16;

  logic       clk;
  logic       rst;
  logic       USB_RX;
  logic       rx_ready;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       USB_CTS;
  logic [2:0] state_out;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  uart_rx_param dut (
    .uart_sampling_clk (clk),
    .rst               (rst),
    .USB_RX            (USB_RX),
    .rx_ready          (rx_ready),
    .clr_err           (clr_err),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .frame_err         (frame_err),
    .parity_err        (parity_err),
    .overrun           (overrun),
    .USB_CTS           (USB_CTS),
    .state_out         (state_out),
    .fifo_count        (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_bits(input logic v, input int n);
    USB_RX = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // par < 0 sends no parity bit; stop_low > 0 holds the stop bit low for that many bit times.
  task automatic send_frame(input logic [7:0] d, input int par, input int stop_low);
    drive_bits(1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bits(d[i], OS);
    if (par >= 0) drive_bits(par[0], OS);
    if (stop_low > 0) drive_bits(1'b0, stop_low * OS);
    drive_bits(1'b1, OS + 8);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; USB_RX = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || parity_err !== 1'b0 ||
        overrun !== 1'b0 || USB_CTS !== 1'b1 || fifo_count !== 3'd0 || state_out !== S_IDLE) begin
      errors++;
      $display("FAIL reset_values: valid=%b data=%h fe=%b pe=%b ovr=%b cts=%b cnt=%0d st=%0d, want 0 00 0 0 0 1 0 0",
               rx_valid, rx_data, frame_err, parity_err, overrun, USB_CTS, fifo_count, state_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_bits(1'b1, 4);
  endtask

  task automatic test_basic();
    int   nvalid = 0;
    logic [7:0] got = 8'h00;
    logic fe = 1'b0, pe = 1'b0, cts_seen = 1'b0;
    rx_ready = 1'b1;
    fork
      send_frame(8'hA5, -1, 0);
      begin
        repeat (10 * OS + 20) begin
          @(negedge clk);
          if (rx_valid) begin nvalid++; got = rx_data; fe = frame_err; pe = parity_err; end
          if (USB_CTS) cts_seen = 1'b1;
        end
      end
    join
    rx_ready = 1'b0;
    checks++;
    if (nvalid != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d, want 1", nvalid); end
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h, want a5", got); end
    checks++;
    if (fe !== 1'b0 || pe !== 1'b0) begin errors++; $display("FAIL basic_flags: fe=%b pe=%b, want 0 0", fe, pe); end
    checks++;
    if (cts_seen !== 1'b0) begin errors++; $display("FAIL basic_cts: cts rose, want 0 throughout"); end
  endtask

  task automatic test_false_start();
    drive_bits(1'b0, 4);
    USB_RX = 1'b1;
    @(negedge clk);
    checks++;
    if (state_out !== S_START) begin errors++; $display("FAIL false_start_enter: state %0d, want %0d", state_out, S_START); end
    drive_bits(1'b1, 20);
    @(negedge clk);
    checks++;
    if (state_out !== S_IDLE || fifo_count !== 3'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL false_start_reject: state=%0d cnt=%0d valid=%b, want 0 0 0", state_out, fifo_count, rx_valid);
    end
  endtask

  task automatic test_break();
    drive_bits(1'b0, 9 * OS + 3 * OS);
    @(negedge clk);
    checks++;
    if (state_out !== S_BREAK || rx_valid !== 1'b1 || frame_err !== 1'b1 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL break_entry: state=%0d valid=%b fe=%b data=%h, want 5 1 1 00", state_out, rx_valid, frame_err, rx_data);
    end
    drive_bits(1'b1, 24);
    @(negedge clk);
    checks++;
    if (state_out !== S_IDLE || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL break_release: state=%0d cnt=%0d, want 0 1", state_out, fifo_count);
    end
    pop_one();
    send_frame(8'h3C, -1, 0);
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h3C || frame_err !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL after_break_char: data=%h fe=%b cnt=%0d, want 3c 0 1", rx_data, frame_err, fifo_count);
    end
    pop_one();
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), -1, 0);
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (USB_CTS !== 1'b0 || fifo_count !== 3'd2) begin
          errors++; $display("FAIL cts_below: cts=%b cnt=%0d, want 0 2", USB_CTS, fifo_count);
        end
      end
      if (i == 3) begin
        checks++;
        if (USB_CTS !== 1'b1 || fifo_count !== 3'd3) begin
          errors++; $display("FAIL cts_at_threshold: cts=%b cnt=%0d, want 1 3", USB_CTS, fifo_count);
        end
      end
      if (i == 4) begin
        checks++;
        if (overrun !== 1'b0 || fifo_count !== 3'd4) begin
          errors++; $display("FAIL full_no_overrun: ovr=%b cnt=%0d, want 0 4", overrun, fifo_count);
        end
      end
    end
    checks++;
    if (overrun !== 1'b1 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL overrun_set: ovr=%b cnt=%0d, want 1 4", overrun, fifo_count);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
        errors++; $display("FAIL drain_%0d: valid=%b data=%h, want 1 %h", i, rx_valid, rx_data, 8'(i));
      end
      @(posedge clk); #1;
      pop_one();
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL drained_sticky: valid=%b ovr=%b, want 0 1", rx_valid, overrun);
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || USB_CTS !== 1'b0) begin
      errors++; $display("FAIL clr_err: ovr=%b cts=%b, want 0 0", overrun, USB_CTS);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 0, 0);
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h07 || parity_err !== 1'b1) begin
      errors++; $display("FAIL parity_bad: data=%h pe=%b, want 07 1", rx_data, parity_err);
    end
    pop_one();
    send_frame(8'h07, 1, 0);
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h07 || parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_good: data=%h pe=%b, want 07 0", rx_data, parity_err);
    end
    pop_one();
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hFF;
    send_frame(8'h11, -1, 0);
    drive_bits(1'b0, OS);
    for (int i = 0; i < 4; i++) drive_bits(d[i], OS);
    drive_bits(d[4], OS / 2);
    @(negedge clk);
    checks++;
    if (state_out !== S_DATA || rx_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset: state=%0d valid=%b, want 2 1", state_out, rx_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state_out !== S_IDLE || rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 3'd0 ||
        USB_CTS !== 1'b1 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d valid=%b data=%h cnt=%0d cts=%b ovr=%b fe=%b, want 0 0 00 0 1 0 0",
               state_out, rx_valid, rx_data, fifo_count, USB_CTS, overrun, frame_err);
    end
    USB_RX = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    drive_bits(1'b1, 4);
    send_frame(8'h5A, -1, 0);
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h5A || fifo_count !== 3'd1 || frame_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_char: data=%h cnt=%0d fe=%b, want 5a 1 0", rx_data, fifo_count, frame_err);
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_break();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, oversampling UART receiver for the USB-serial link, the next generation of the fixed 8N1 receiver. Synchronises RX, validates the start bit at mid-bit and samples data, optional parity and 1–2 stop bits at bit centre. Received characters and their error flags are buffered in a small FIFO with a valid/ready output. USB_CTS hardware flow control is driven from FIFO occupancy.

## Interface
- DATA_BITS, 8: character width, 5–9.
- OVERSAMPLE, 16: sampling-clock cycles per bit; even, at least 4.
- STOP_BITS, 1: 1 or 2.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; used only with UART_RX_PARITY_EN.
- FIFO_DEPTH, 4: entries; power of two, at least 2.
- CTS_THRESHOLD, FIFO_DEPTH-1: occupancy at or above which USB_CTS = 1.
- uart_sampling_clk  in  1  sampling clock, OVERSAMPLE × baud.
- rst  in  1  reset, asynchronous, active-high.
- USB_RX  in  1  serial input, idle high.
- rx_ready  in  1  consumer accepts head entry.
- clr_err  in  1  one-cycle pulse; clears overrun.
- rx_data  out  DATA_BITS  FIFO head data.
- rx_valid  out  1  FIFO non-empty.
- frame_err  out  1  head entry had a low stop bit.
- parity_err  out  1  head entry failed parity.
- overrun  out  1  sticky: a character was dropped because the FIFO was full.
- USB_CTS  out  1  0 = PC cleared to send.
- state_out  out  3  current FSM state, debug.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.

## Operation
- USB_RX passes through a 2-flop synchroniser that resets to 1. All references below to "rx" mean the synchronised value.
- FSM states: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK.
- Sample counter cnt has $clog2(OVERSAMPLE) bits. Bit counter counts up to DATA_BITS.
- S_IDLE: if rx = 0, go to S_START with cnt = 0.
- S_START:
  - cnt increments each cycle.
  - At cnt = OVERSAMPLE/2-1: if rx = 1, it is a false start; return to S_IDLE.
  - Otherwise go to S_DATA with cnt = 0 and bit count = 0.
- S_DATA:
  - At cnt = OVERSAMPLE-1, shift rx in LSB-first and reset cnt to 0.
  - After the DATA_BITS-th sample, go to S_PARITY if the macro is defined, else S_STOP.
- S_PARITY: sample at cnt = OVERSAMPLE-1. perr = XOR(data, parity bit) ≠ PARITY_ODD.
- S_STOP:
  - Sample each stop bit at cnt = OVERSAMPLE-1.
  - Any low stop bit sets ferr.
  - After the last stop sample, push {perr, ferr, data}.
  - Then go to S_IDLE if ferr = 0, else S_BREAK.
- S_BREAK: hold until rx = 1, then go to S_IDLE. A held-low line never re-triggers a start.
- FIFO:
  - Show-ahead: rx_data, frame_err and parity_err reflect the head entry.
  - Pop when rx_valid && rx_ready.
- Push when the FIFO is full and there is no pop in the same cycle:
  - The character is dropped and overrun is set.
  - overrun is cleared only by clr_err.
  - If clr_err and a new overrun occur in the same cycle, the set wins.
- Push and pop in the same cycle when full: both succeed; no overrun.
- Push and pop in the same cycle when empty: the push is stored; rx_valid rises next cycle (no bypass).
- USB_CTS is a register: 1 when fifo_count ≥ CTS_THRESHOLD, else 0.

## Timing
- Reset values:
  - state = S_IDLE; FIFO empty.
  - rx_valid, frame_err, parity_err, overrun = 0.
  - rx_data = 0; USB_CTS = 1; fifo_count = 0.
- Reset mid-frame aborts the frame; no partial push.
- Synchroniser latency is 2 cycles.
- With the start edge entering S_START at t0:
  - Data bit k is sampled at t0 + OVERSAMPLE/2 + (k+1)·OVERSAMPLE - 1.
  - The push occurs the cycle after the final stop sample.
  - rx_valid rises the following cycle.
- The return to S_IDLE at mid-stop gives half a bit of resynchronisation slack.
- USB_CTS lags fifo_count by one cycle.

## Configuration
- UART_RX_PARITY_EN defined: the S_PARITY state exists and is checked per PARITY_ODD.
- Not defined: S_PARITY is never entered, no parity bit is expected, parity_err is tied to 0, and the FIFO entry width excludes perr.

## Structure
- Package uart_pkg holds:
  - the state enum (3-bit, values in the order above);
  - the rx_entry_t struct {perr, ferr, data} parameterised via DATA_BITS in the using module.
- Sub-module uart_rx_fifo: synchronous FIFO with DEPTH parameter and push/pop/full/empty/count, instantiated once.

## Test plan
Bench defaults: OVERSAMPLE=16, DATA_BITS=8, FIFO_DEPTH=4, 1 stop bit.
- Send 0xA5, 8N1, with rx_ready=1 → one-cycle rx_valid with rx_data=0xA5 and no error flags; USB_CTS stays 0.
- Pulse USB_RX low for 4 cycles → no push; state_out returns to S_IDLE; fifo_count=0.
- Send 0x00 with the stop bit held low for 3 bit times → entry with frame_err=1; FSM in S_BREAK until the line rises, then S_IDLE; the next 0x3C is received clean.
- Send 5 bytes 0x01–0x05 with rx_ready=0:
  - USB_CTS=1 after the 3rd push.
  - The 5th byte is dropped and overrun=1.
  - Draining yields 0x01–0x04 in order.
  - clr_err then clears overrun.
- With the macro defined and even parity, send 0x07 with parity bit 0 → parity_err=1; with parity bit 1 → parity_err=0.
- Assert rst during data bit 4 → all outputs at reset values immediately; the next 0x5A frame is received correctly.
